// File: rtl/fsk_word_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsk_word_receiver_pkg
// Description : Shared types and frame-size constants for the FSK word
//               receiver (state encoding, data width, total frame length).
// Revision    : 1.0 - initial release
// ============================================================================
package fsk_word_receiver_pkg;

  // Payload bits per frame and full frame length (start + data + stop).
  localparam int DATA_BITS  = 32;
  localparam int FRAME_BITS = DATA_BITS + 2;

  // Receiver framing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fsk_tone_decider.sv
`default_nettype none
// ============================================================================
// Module      : fsk_tone_decider
// Description : Registered nearest-tone decision. Outputs 1 (mark) when the
//               received frequency word is at least as close to the mark tone
//               as to the space tone; ties resolve to mark.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_tone_decider
  import fsk_word_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] freq_in,
  input  logic [31:0] mark_frq,
  input  logic [31:0] space_frq,
  output logic        tone
);

  // 33-bit magnitudes so the comparison never overflows
  logic [32:0] w_diff_mark;
  logic [32:0] w_diff_space;
  logic        r_tone;

  // Absolute distance of the received word from each reference tone
  always_comb begin
    w_diff_mark  = '0;
    w_diff_space = '0;
    if (freq_in >= mark_frq) w_diff_mark = {1'b0, freq_in} - {1'b0, mark_frq};
    else                     w_diff_mark = {1'b0, mark_frq} - {1'b0, freq_in};
    if (freq_in >= space_frq) w_diff_space = {1'b0, freq_in} - {1'b0, space_frq};
    else                      w_diff_space = {1'b0, space_frq} - {1'b0, freq_in};
  end

  // Register the decision every cycle; equal distances count as mark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tone <= 1'b0;
    else     r_tone <= (w_diff_mark <= w_diff_space);
  end

  assign tone = r_tone;

endmodule
`default_nettype wire

// File: rtl/fsk_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : fsk_word_receiver
// Description : Asynchronous-frame FSK receiver. Detects a start bit after an
//               idle mark, verifies it at mid-symbol, samples DATA_BITS bits
//               LSB first at one-symbol spacing, then checks the stop bit and
//               publishes the word (word_valid) or flags frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_word_receiver #(
  parameter int DATA_BITS = fsk_word_receiver_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          symbol_dur,
  input  logic [31:0]          mark_frq,
  input  logic [31:0]          space_frq,
  input  logic [31:0]          freq_in,
  output logic [DATA_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 tone
);
  import fsk_word_receiver_pkg::*;

  localparam int                  BIT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0]    c_last_bit = BIT_W'(DATA_BITS - 1);

  state_t                 r_state,  w_state_nxt;
  logic [31:0]            r_cnt,    w_cnt_nxt;
  logic [31:0]            r_sym,    w_sym_nxt;
  logic [BIT_W-1:0]       r_bit,    w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift,  w_shift_nxt;
  logic [DATA_BITS-1:0]   r_word,   w_word_nxt;
  logic                   r_armed,  w_armed_nxt;
  logic                   r_valid,  w_valid_nxt;
  logic                   r_ferr,   w_ferr_nxt;
  logic                   w_tone;
  logic [31:0]            w_half;
  logic [DATA_BITS-1:0]   w_shift_ins;

  fsk_tone_decider u_tone (
    .clk       (clk),
    .rst       (rst),
    .freq_in   (freq_in),
    .mark_frq  (mark_frq),
    .space_frq (space_frq),
    .tone      (w_tone)
  );

  // Mid-start check point, taken from the latched symbol length
  assign w_half = {1'b0, r_sym[31:1]};

  // Bits arrive LSB first: insert at the top and shift right, so after
  // DATA_BITS samples the first bit lands in position 0
  generate
    if (DATA_BITS > 1) begin : g_shift_wide
      assign w_shift_ins = {w_tone, r_shift[DATA_BITS-1:1]};
    end else begin : g_shift_one
      assign w_shift_ins = w_tone;
    end
  endgenerate

  // Next-state, counter and output-pulse logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sym_nxt   = r_sym;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_word_nxt  = r_word;
    w_armed_nxt = r_armed;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tone) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          // First space after an idle mark; too-short symbols are ignored
          // and the line must go back to mark before another attempt
          w_armed_nxt = 1'b0;
          w_sym_nxt   = symbol_dur;
          if (symbol_dur >= 32'd2) begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = 32'd1;
          end
        end
      end
      ST_START: begin
        if (r_cnt == w_half) begin
          if (w_tone) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = 32'd1;
            w_bit_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_DATA: begin
        if (r_cnt == r_sym) begin
          w_shift_nxt = w_shift_ins;
          w_cnt_nxt   = 32'd1;
          if (r_bit == c_last_bit) w_state_nxt = ST_STOP;
          else                     w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_STOP: begin
        if (r_cnt == r_sym) begin
          w_state_nxt = ST_IDLE;
          if (w_tone) begin
            w_word_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters, shift register and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sym   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_armed <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_word  <= w_word_nxt;
      r_armed <= w_armed_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != ST_IDLE);
  assign tone       = w_tone;

endmodule
`default_nettype wire

// File: doc/fsk_word_receiver.md
FSK_WORD_RECEIVER -- requirements
Module: fsk_word_receiver

Interface
REQ-001 Parameter DATA_BITS, default 32: data bits per frame.
REQ-002 Port clk  input  1: single clock, rising edge.
REQ-003 Port rst  input  1: asynchronous, active-high reset.
REQ-004 Port symbol_dur  input  32: symbol length in clk cycles.
REQ-005 Port mark_frq  input  32: tone word for logic 1.
REQ-006 Port space_frq  input  32: tone word for logic 0.
REQ-007 Port freq_in  input  32: received frequency word, sampled every cycle.
REQ-008 Port word_out  output  32: last correctly framed word.
REQ-009 Port word_valid  output  1: one-cycle pulse when word_out updates.
REQ-010 Port frame_err  output  1: one-cycle pulse when the stop bit is bad.
REQ-011 Port busy  output  1: high whenever the state is not IDLE.
REQ-012 Port tone  output  1: registered tone decision (1 = mark).

Function
REQ-013 The block SHALL handle this frame format: start bit (space), DATA_BITS data bits LSB first, then stop bit (mark); line idles at mark.
REQ-014 tone SHALL register each cycle as 1 when |freq_in-mark_frq| <= |freq_in-space_frq|, using 33-bit unsigned absolute differences; ties SHALL decode as mark.
REQ-015 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-016 IDLE -> START SHALL occur on the first cycle tone==0 after at least one cycle of tone==1 since entering IDLE; symbol_dur SHALL be latched on this transition.
REQ-017 If the latched symbol_dur is < 2, the block SHALL return to IDLE without outputs.
REQ-018 In START, tone SHALL be checked half = floor(symbol_dur/2) cycles after the first space cycle; mark -> IDLE (glitch reject, no outputs); space -> DATA.
REQ-019 In DATA, each bit SHALL be sampled exactly symbol_dur cycles after the previous sample and written to bit position 0..DATA_BITS-1 in order.
REQ-020 After DATA_BITS samples the FSM SHALL enter STOP and sample once more symbol_dur cycles later.
REQ-021 A STOP sample of mark SHALL load word_out and pulse word_valid on the next cycle; a sample of space SHALL pulse frame_err on the next cycle and leave word_out unchanged.
REQ-022 After the STOP sample the FSM SHALL enter IDLE and require tone==1 before re-arming (REQ-016).
REQ-023 word_valid and frame_err SHALL never be high together and SHALL each last exactly one cycle.
REQ-024 Changes to symbol_dur, mark_frq or space_frq mid-frame SHALL NOT alter frame timing; tone decisions use live values.
REQ-025 Cycle counters SHALL be 32 bits wide, and no counter SHALL wrap within a frame for any symbol_dur >= 2.

Reset
REQ-026 While rst is high, the block SHALL hold state IDLE, all counters and the shift register at 0, and word_out=0, word_valid=0, frame_err=0, busy=0, tone=0.
REQ-027 Asserting rst mid-frame SHALL abort the frame with no pulse; after release, a frame SHALL be accepted only after a mark cycle is seen.

Structure
REQ-028 A shared package SHALL hold the state enum, DATA_BITS and FRAME_BITS=DATA_BITS+2.
REQ-029 Tone decision SHALL be a sub-module fsk_tone_decider (inputs freq_in, mark_frq, space_frq; registered output tone).
REQ-030 Target size is 120-400 RTL lines, with no memories and no multipliers.

Verification
REQ-031 Drive symbol_dur=15, mark=1000, space=500 with a clean frame of 0xA5A51234 after 20 idle cycles; this SHALL produce word_out=0xA5A51234, word_valid for 1 cycle 7+33*15+1 cycles after the first registered space, and frame_err=0.
REQ-032 Drive space for 3 cycles and then mark (symbol_dur=15); busy SHALL drop after the mid-start check, with no word_valid and no frame_err.
REQ-033 Drive a frame of 0x0000FFFF with the stop bit forced to space; this SHALL produce a frame_err pulse and leave word_out at its prior value.
REQ-034 Drive freq_in=750 with mark=1000 and space=500; tone SHALL be 1, and freq_in=749 SHALL give tone=0.
REQ-035 Assert rst at data bit 10, release it, then send a clean frame of 0x12345678; there SHALL be no pulse for the aborted frame, then word_out=0x12345678 with one word_valid.
REQ-036 Drive back-to-back frames of 0x1 and 0xFFFFFFFF with one idle mark symbol between them (symbol_dur=4); this SHALL produce two word_valid pulses in order.
